// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller.
// Holds the state encoding (also exported on the debug state output),
// opcode constants, datapath mux/ALU encodings, the control-word struct
// and an opcode legality helper.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_J, OP_ADDI, OP_ANDI: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_if.sv
// Control bundle between the sequencing controller and the datapath.
// master: controller side (samples opcode/mem_ready, drives controls).
// slave : datapath side.
// Memory handshake: the controller holds MemRead/MemWrite and IorD steady
// for as long as an access is pending; the access completes in the cycle
// where mem_ready=1, and only then does the state advance. There is no
// separate request/accept phase: the strobe itself is the request.
interface multicycle_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       BranchEq;
    logic       BranchNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, instr_done, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
               ALUOp, PCSource, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_state_decode.sv
// Combinational output decode for the multi-cycle controller.
// Ports: state_i (current state), op_q_i (opcode latched in DECODE),
// opcode_i (live IR opcode, used only for the DECODE illegal flag),
// mem_ready_i (memory handshake), reset_i, ctrl_o (full control word).
module mc_state_decode
    import multicycle_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_q_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       reset_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC load only in the cycle the fetch completes.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = !is_known_op(opcode_i);
            end
            S_MEMADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.iord       = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_B;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_source  = PCSRC_ALUOUT;
                ctrl_o.branch_eq  = (op_q_i == OP_BEQ);
                ctrl_o.branch_ne  = (op_q_i == OP_BNE);
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_q_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
            end
            S_IMM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset abandons the current instruction: no side effect may leak.
        if (reset_i) begin
            ctrl_o.pc_write   = 1'b0;
            ctrl_o.ir_write   = 1'b0;
            ctrl_o.mem_read   = 1'b0;
            ctrl_o.mem_write  = 1'b0;
            ctrl_o.reg_write  = 1'b0;
            ctrl_o.branch_eq  = 1'b0;
            ctrl_o.branch_ne  = 1'b0;
            ctrl_o.instr_done = 1'b0;
            ctrl_o.illegal_op = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller (top level).
// Ports: clk, reset (sync, active-high), bus (multicycle_if.master:
// opcode/mem_ready in, datapath controls and debug state out).
// Holds the state register, the latched opcode and next-state logic;
// output decoding lives in mc_state_decode.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    multicycle_if.master bus
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADDR;
                    OP_RTYPE:         state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADDR:  state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_state_decode u_decode (
        .state_i     (state_q),
        .op_q_i      (op_q),
        .opcode_i    (bus.opcode),
        .mem_ready_i (bus.mem_ready),
        .reset_i     (reset),
        .ctrl_o      (ctrl)
    );

    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.BranchEq   = ctrl.branch_eq;
    assign bus.BranchNe   = ctrl.branch_ne;
    assign bus.IorD       = ctrl.iord;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.PCSource   = ctrl.pc_source;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A per-instruction model
// expands each opcode (plus chosen wait counts) into its expected cycle
// sequence and per-cycle control word, and separately predicts where the
// retire/illegal pulse lands from the cycles-per-instruction table.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Debug state codes as published on the state output.
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADDR = 2, P_MEMREAD = 3;
    localparam int P_MEMWB = 4, P_MEMWRITE = 5, P_EXECUTE = 6, P_RTYPE_WB = 7;
    localparam int P_BRANCH = 8, P_JUMP = 9, P_IMM_EXEC = 10, P_IMM_WB = 11;

    localparam int W = 23;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         mr_q[$];
    logic [5:0]   opc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic known(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c};
    endfunction

    // Zero-wait cycles per instruction.
    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'h23:                      return 5;
            6'h2b, 6'h00, 6'h08, 6'h0c: return 4;
            6'h04, 6'h05, 6'h02:        return 3;
            default:                    return 2;
        endcase
    endfunction

    // Expected {state, PCWrite, BranchEq, BranchNe, IorD, MemRead, MemWrite,
    // IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    // instr_done, illegal_op} for one cycle.
    function automatic logic [W-1:0] exp_vec(input int p, input logic [5:0] op,
                                             input logic mr, input logic rst);
        logic pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill;
        logic [1:0] sb, aop, pcs;
        logic [3:0] st;
        {pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        st = p[3:0];
        case (p)
            P_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            P_DECODE:   begin sb = 2'b11; ill = !known(op); end
            P_MEMADDR:  begin sa = 1; sb = 2'b10; end
            P_MEMREAD:  begin iord = 1; mrd = 1; end
            P_MEMWB:    begin m2r = 1; rw = 1; done = 1; end
            P_MEMWRITE: begin iord = 1; mwr = 1; done = mr; end
            P_EXECUTE:  begin sa = 1; aop = 2'b10; end
            P_RTYPE_WB: begin rdst = 1; rw = 1; done = 1; end
            P_BRANCH:   begin sa = 1; aop = 2'b01; pcs = 2'b01; done = 1;
                              beq = (op == 6'h04); bne = (op == 6'h05); end
            P_JUMP:     begin pcs = 2'b10; pcw = 1; done = 1; end
            P_IMM_EXEC: begin sa = 1; sb = 2'b10; aop = (op == 6'h0c) ? 2'b11 : 2'b00; end
            P_IMM_WB:   begin rw = 1; done = 1; end
            default: ;
        endcase
        if (rst) {pcw, irw, mrd, mwr, rw, beq, bne, done, ill} = '0;
        return {st, pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, sa,
                sb, aop, pcs, done, ill};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.state, bus.PCWrite, bus.BranchEq, bus.BranchNe, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                bus.instr_done, bus.illegal_op};
    endfunction

    // One clock cycle: drive at negedge, sample mid low phase.
    task automatic cyc(input logic mr, input logic [5:0] opc, input logic rst,
                       input logic [W-1:0] exp, input string tag, output logic pulse);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.opcode    = opc;
        reset         = rst;
        #2;
        check($sformatf("%s st%0d", tag, exp[W-1 -: 4]), {9'b0, observed()}, {9'b0, exp});
        pulse = bus.instr_done | bus.illegal_op;
    endtask

    task automatic push_ph(input int p, input logic mr, input logic [5:0] op, input logic [5:0] drv);
        exp_q.push_back(exp_vec(p, op, mr, 1'b0));
        mr_q.push_back(mr);
        opc_q.push_back(drv);
    endtask

    function automatic logic [5:0] noise();
        return 6'($urandom_range(0, 63));
    endfunction

    // Expand one instruction into its cycle list, then run and score it.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input string tag);
        int n, first;
        logic pulse;
        for (int i = 0; i < wf; i++) push_ph(P_FETCH, 1'b0, op, noise());
        push_ph(P_FETCH, 1'b1, op, noise());
        push_ph(P_DECODE, 1'($urandom_range(0, 1)), op, op);
        case (op)
            6'h23: begin
                push_ph(P_MEMADDR, 1'($urandom_range(0, 1)), op, noise());
                for (int i = 0; i < wm; i++) push_ph(P_MEMREAD, 1'b0, op, noise());
                push_ph(P_MEMREAD, 1'b1, op, noise());
                push_ph(P_MEMWB, 1'($urandom_range(0, 1)), op, noise());
            end
            6'h2b: begin
                push_ph(P_MEMADDR, 1'($urandom_range(0, 1)), op, noise());
                for (int i = 0; i < wm; i++) push_ph(P_MEMWRITE, 1'b0, op, noise());
                push_ph(P_MEMWRITE, 1'b1, op, noise());
            end
            6'h00: begin
                push_ph(P_EXECUTE, 1'($urandom_range(0, 1)), op, noise());
                push_ph(P_RTYPE_WB, 1'($urandom_range(0, 1)), op, noise());
            end
            6'h04, 6'h05: push_ph(P_BRANCH, 1'($urandom_range(0, 1)), op, noise());
            6'h02:        push_ph(P_JUMP, 1'($urandom_range(0, 1)), op, noise());
            6'h08, 6'h0c: begin
                push_ph(P_IMM_EXEC, 1'($urandom_range(0, 1)), op, noise());
                push_ph(P_IMM_WB, 1'($urandom_range(0, 1)), op, noise());
            end
            default: ;
        endcase
        n = exp_q.size();
        first = -1;
        for (int i = 0; i < n; i++) begin
            cyc(mr_q.pop_front(), opc_q.pop_front(), 1'b0, exp_q.pop_front(), tag, pulse);
            if (pulse && first < 0) first = i;
        end
        check({tag, " pulse_cycle"}, 32'(first),
              32'(cpi(op) + wf + ((op == 6'h23 || op == 6'h2b) ? wm : 0) - 1));
    endtask

    logic [5:0] op_tab [0:10];

    initial begin
        logic p;
        op_tab = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c,
                   6'h3f, 6'h01, 6'h2a};
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'h00;

        // Reset: FETCH with every strobe suppressed.
        cyc(1'b1, 6'h23, 1'b1, exp_vec(P_FETCH, 6'h00, 1'b1, 1'b1), "reset", p);
        cyc(1'b0, 6'h00, 1'b1, exp_vec(P_FETCH, 6'h00, 1'b0, 1'b1), "reset", p);

        run_instr(6'h23, 0, 0, "lw");
        run_instr(6'h2b, 0, 3, "sw_wait");
        run_instr(6'h04, 0, 0, "beq");
        run_instr(6'h05, 0, 0, "bne");
        run_instr(6'h08, 0, 0, "addi");
        run_instr(6'h0c, 0, 0, "andi");
        run_instr(6'h02, 0, 0, "j");
        run_instr(6'h3f, 0, 0, "illegal");
        run_instr(6'h00, 2, 0, "rtype_fwait");

        // Reset while lw waits in MEMREAD.
        cyc(1'b1, 6'h00, 1'b0, exp_vec(P_FETCH, 6'h23, 1'b1, 1'b0), "rst_mid", p);
        cyc(1'b0, 6'h23, 1'b0, exp_vec(P_DECODE, 6'h23, 1'b0, 1'b0), "rst_mid", p);
        cyc(1'b0, 6'h00, 1'b0, exp_vec(P_MEMADDR, 6'h23, 1'b0, 1'b0), "rst_mid", p);
        cyc(1'b0, 6'h00, 1'b0, exp_vec(P_MEMREAD, 6'h23, 1'b0, 1'b0), "rst_mid", p);
        cyc(1'b0, 6'h00, 1'b1, exp_vec(P_MEMREAD, 6'h23, 1'b0, 1'b1), "rst_mid", p);
        run_instr(6'h2b, 0, 1, "after_rst");

        for (int k = 0; k < 60; k++) begin
            run_instr(op_tab[$urandom_range(0, 10)], $urandom_range(0, 3),
                      $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for a multi-cycle MIPS datapath: one memory, one ALU, and the IR, A, B, ALUOut and MDR registers. It supports the existing instruction subset (R-type, lw, sw, beq, bne, j, addi, andi). It steps each instruction through fetch, decode, execute, memory and write-back states, and stalls on a memory-ready handshake. It sits beside the datapath and replaces the single-cycle main decoder.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- BranchEq / BranchNe  out  1 each  conditional PC load when ALU zero=1 / zero=0
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination select: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded, 11 and
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on each retired instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state, for debug

## Operation
- Moore FSM with a 4-bit state register. Outputs decode from the state. Stalling states additionally gate their writes with mem_ready.
- Any signal not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. If mem_ready=0, stay in FETCH; otherwise go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target goes into ALUOut). Registers opcode into op_q. Next state by opcode:
  - 0x23 or 0x2b → MEMADDR
  - 0x00 → EXECUTE
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08 or 0x0c → IMM_EXEC
  - other → FETCH, with illegal_op=1
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMREAD if op_q=lw, otherwise MEMWRITE.
- MEMREAD: IorD=1, MemRead=1. Stay while mem_ready=0; then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next is FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Stay while mem_ready=0. When mem_ready=1, set instr_done=1 and go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. BranchEq=(op_q==beq), BranchNe=(op_q==bne), instr_done=1. Next is FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Next is FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi. Next is IMM_WB.
- IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next is FETCH.
- Unused state codes → FETCH on the next edge, with all outputs 0.

## Timing
- Reset:
  - reset=1 at an edge: state←FETCH and op_q←0.
  - While reset=1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, BranchEq, BranchNe, instr_done and illegal_op are forced to 0 combinationally.
  - Reset mid-instruction abandons it; no write strobe asserts in the reset cycle.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3, illegal 2.
- Each wait cycle (mem_ready=0) adds 1 cycle in FETCH, MEMREAD or MEMWRITE. During a wait:
  - MemRead/MemWrite and the address selects hold steady.
  - IRWrite, PCWrite and instr_done stay 0.
- opcode is ignored outside DECODE. A change on opcode in other states has no effect.
- instr_done and illegal_op are mutually exclusive and never high in consecutive cycles.

## Structure
- Shared package multicycle_pkg holds:
  - state encodings (FETCH=0 … IMM_WB=11)
  - opcode constants (OP_RTYPE=0x00, OP_LW=0x23, OP_SW=0x2b, OP_BEQ=0x04, OP_BNE=0x05, OP_J=0x02, OP_ADDI=0x08, OP_ANDI=0x0c)
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, mc_state_decode: purely combinational, maps (state, op_q, mem_ready, reset) to the control outputs.
- The top level holds only the state register, op_q and the next-state logic.

## Test plan
- Reset, then lw (0x23) with mem_ready=1:
  - states 0→1→2→3→4→0
  - IRWrite and PCWrite in cycle 1; RegWrite with MemtoReg=1 in cycle 5; instr_done in cycle 5
- sw with mem_ready low for 3 cycles in MEMWRITE: MemWrite held for 4 cycles, instr_done only in the last, total 7 cycles.
- beq, then bne: BRANCH state with ALUOp=01, PCSource=01; BranchEq=1 then BranchNe=1; 3 cycles each.
- addi then andi:
  - IMM_EXEC ALUOp=00, then 11
  - IMM_WB RegWrite=1 with RegDst=0
  - j: PCWrite=1, PCSource=10
- opcode 0x3f: illegal_op pulse in DECODE, return to FETCH, no RegWrite, MemWrite or PCWrite beyond fetch.
- reset asserted in MEMREAD while mem_ready=0: all strobes 0 that cycle, state=FETCH next cycle.
